// File: rtl/iserdes_bitslip_trainer.sv
// Word-alignment trainer for an 8:1 deserializer: issues bitslip pulses until q matches
// TRAIN_PATTERN for MATCH_COUNT consecutive CLKDIV cycles, or gives up after all 8 alignments.
module iserdes_bitslip_trainer #(
  parameter logic [7:0] TRAIN_PATTERN = 8'hB4,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_COUNT   = 8
) (
  input  logic       CLKDIV,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] q,
  output logic       bitslip,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [2:0] slip_count,
  output logic       lock_lost
);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MATCH_LAST  = 4'(MATCH_COUNT - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [3:0] match_cnt, match_cnt_nxt;
  logic [2:0] attempt_cnt, attempt_cnt_nxt;
  logic [2:0] slip_count_nxt;
  logic       lock_lost_nxt;
  logic       pattern_hit;

  assign pattern_hit = (q == TRAIN_PATTERN);

  always_comb begin
    state_nxt       = state;
    settle_cnt_nxt  = settle_cnt;
    match_cnt_nxt   = match_cnt;
    attempt_cnt_nxt = attempt_cnt;
    slip_count_nxt  = slip_count;
    lock_lost_nxt   = lock_lost;
    case (state)
      IDLE, LOCKED, FAIL: begin
        if (start) begin
          state_nxt       = SETTLE;
          settle_cnt_nxt  = 4'd0;
          match_cnt_nxt   = 4'd0;
          attempt_cnt_nxt = 3'd0;
          lock_lost_nxt   = 1'b0;
        end else if (state == LOCKED && !pattern_hit) begin
          lock_lost_nxt = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
        else                           settle_cnt_nxt = settle_cnt + 4'd1;
      end
      CHECK: begin
        if (pattern_hit) begin
          if (match_cnt == MATCH_LAST) state_nxt = LOCKED;
          else                         match_cnt_nxt = match_cnt + 4'd1;
        end else begin
          match_cnt_nxt = 4'd0;
          if (attempt_cnt == 3'd7) begin
            state_nxt = FAIL;
          end else begin
            state_nxt      = SLIP;
            slip_count_nxt = slip_count + 3'd1;
          end
        end
      end
      SLIP: begin
        // The slip already happened on entry; count the attempt and re-settle.
        attempt_cnt_nxt = attempt_cnt + 3'd1;
        settle_cnt_nxt  = 4'd0;
        state_nxt       = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      state       <= IDLE;
      settle_cnt  <= 4'd0;
      match_cnt   <= 4'd0;
      attempt_cnt <= 3'd0;
      slip_count  <= 3'd0;
      lock_lost   <= 1'b0;
      bitslip     <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_cnt_nxt;
      match_cnt   <= match_cnt_nxt;
      attempt_cnt <= attempt_cnt_nxt;
      slip_count  <= slip_count_nxt;
      lock_lost   <= lock_lost_nxt;
      bitslip     <= (state_nxt == SLIP);
      busy        <= (state_nxt == SETTLE) || (state_nxt == CHECK) || (state_nxt == SLIP);
      locked      <= (state_nxt == LOCKED);
      fail        <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_iserdes_bitslip_trainer.sv
// Bench for iserdes_bitslip_trainer: directed scenarios with literal timing pins, then random
// traffic compared every cycle against a timeline-based model driven by a rotating-word deserializer.
module tb_iserdes_bitslip_trainer;

  localparam logic [7:0] PAT = 8'hB4;
  localparam int S = 4;
  localparam int M = 8;

  logic       CLKDIV = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [7:0] q = 8'h00;
  logic       bitslip, busy, locked, fail, lock_lost;
  logic [2:0] slip_count;

  iserdes_bitslip_trainer #(.TRAIN_PATTERN(PAT), .SETTLE_CYCLES(S), .MATCH_COUNT(M)) dut (
    .CLKDIV(CLKDIV), .RST(RST), .start(start), .q(q),
    .bitslip(bitslip), .busy(busy), .locked(locked), .fail(fail),
    .slip_count(slip_count), .lock_lost(lock_lost)
  );

  always #5 CLKDIV = ~CLKDIV;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: training is described by the absolute cycle at which comparing starts.
  bit m_valid, m_train, m_locked, m_fail, m_lost, m_bitslip;
  int m_chk, m_run, m_att, m_slips;

  int des_slips = 0;
  logic [7:0] hist [0:63];
  int slip_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[n +: 8];
  endfunction

  task automatic model_update();
    m_bitslip = 0;
    if (RST) begin
      m_valid = 1; m_train = 0; m_locked = 0; m_fail = 0; m_lost = 0; m_slips = 0;
    end else if (!m_train && start) begin
      m_train = 1; m_chk = cyc + 1 + S; m_run = 0; m_att = 0;
      m_lost = 0; m_locked = 0; m_fail = 0;
    end else if (m_train) begin
      if (cyc >= m_chk) begin
        if (q == PAT) begin
          m_run++;
          if (m_run == M) begin m_train = 0; m_locked = 1; end
        end else begin
          m_run = 0;
          if (m_att == 7) begin
            m_train = 0; m_fail = 1;
          end else begin
            m_bitslip = 1; m_att++; m_slips = (m_slips + 1) % 8;
            m_chk = cyc + 2 + S;
          end
        end
      end
    end else if (m_locked && q != PAT) begin
      m_lost = 1;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge CLKDIV);
    #1;
    cyc++;
    if (m_valid) begin
      chk("bitslip", int'(bitslip), int'(m_bitslip));
      chk("busy", int'(busy), int'(m_train));
      chk("locked", int'(locked), int'(m_locked));
      chk("fail", int'(fail), int'(m_fail));
      chk("slip_count", int'(slip_count), m_slips);
      chk("lock_lost", int'(lock_lost), int'(m_lost));
    end
    if (bitslip) des_slips++;
  endtask

  function automatic logic [7:0] q_for(input int mode, input int k);
    logic [7:0] r;
    case (mode)
      0: return PAT;
      1: return rot(PAT, (k - des_slips) & 7);
      default: begin
        r = 8'($urandom_range(1, 255));
        return PAT ^ r;
      end
    endcase
  endfunction

  task automatic scenario(input int mode, input int k, input int corrupt_at,
                          input logic [63:0] start_mask, input logic [63:0] rst_mask,
                          input int ncyc);
    start = 0; RST = 1;
    step(); step();
    RST = 0;
    des_slips = 0;
    slip_q.delete();
    for (int i = 0; i < 64; i++) hist[i] = 8'h00;
    hist[0] = {slip_count, lock_lost, fail, locked, busy, bitslip};
    for (int r = 0; r < ncyc; r++) begin
      start = start_mask[r];
      RST   = rst_mask[r];
      q     = (r == corrupt_at) ? ~PAT : q_for(mode, k);
      step();
      hist[r + 1] = {slip_count, lock_lost, fail, locked, busy, bitslip};
      if (bitslip) slip_q.push_back(r + 1);
    end
    start = 0; RST = 0;
  endtask

  function automatic int first_with(input int bitpos, input int ncyc);
    for (int i = 0; i <= ncyc; i++) if (hist[i][bitpos]) return i;
    return -1;
  endfunction

  initial begin
    // Reset state
    step(); step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_slip_count", int'(slip_count), 0);

    // Aligned from the start: busy 1..12, locked at 13, no slips
    scenario(0, 0, -1, 64'h1, 64'h0, 20);
    chk("s1_busy1", int'(hist[1][1]), 1);
    chk("s1_busy12", int'(hist[12][1]), 1);
    chk("s1_busy13", int'(hist[13][1]), 0);
    chk("s1_lock_rise", first_with(2, 20), 13);
    chk("s1_nslips", slip_q.size(), 0);
    chk("s1_slip_count", int'(hist[13][7:5]), 0);

    // Three slips needed
    scenario(1, 3, -1, 64'h1, 64'h0, 40);
    chk("s2_nslips", slip_q.size(), 3);
    if (slip_q.size() == 3) begin
      chk("s2_slip0", slip_q[0], 6);
      chk("s2_slip1", slip_q[1], 12);
      chk("s2_slip2", slip_q[2], 18);
    end
    chk("s2_lock_rise", first_with(2, 40), 31);
    chk("s2_slip_count", int'(hist[31][7:5]), 3);

    // Never aligns
    scenario(2, 0, -1, 64'h1, 64'h0, 55);
    chk("s3_nslips", slip_q.size(), 7);
    chk("s3_fail_rise", first_with(3, 55), 48);
    chk("s3_busy48", int'(hist[48][1]), 0);
    chk("s3_slip_count", int'(hist[48][7:5]), 7);

    // Five matches then a mismatch restarts the count
    scenario(0, 0, 10, 64'h1, 64'h0, 30);
    chk("s4_nslips", slip_q.size(), 1);
    if (slip_q.size() == 1) chk("s4_slip0", slip_q[0], 11);
    chk("s4_lock_rise", first_with(2, 30), 24);

    // Reset mid-training
    scenario(0, 0, -1, (64'h1 << 0) | (64'h1 << 10) | (64'h1 << 11),
             (64'h1 << 9) | (64'h1 << 10), 20);
    chk("s5_all_zero10", int'(hist[10]), 0);
    chk("s5_start10_ignored", int'(hist[11][1]), 0);
    chk("s5_start11_taken", int'(hist[12][1]), 1);

    // Corruption while locked, then retrain
    scenario(1, 2, 28, (64'h1 << 0) | (64'h1 << 32), 64'h0, 50);
    chk("s6_lock_rise", first_with(2, 50), 25);
    chk("s6_lost", int'(hist[29][4]), 1);
    chk("s6_still_locked", int'(hist[29][2]), 1);
    chk("s6_lost_cleared", int'(hist[33][4]), 0);
    chk("s6_retrain_busy", int'(hist[33][1]), 1);
    chk("s6_slip_kept", int'(hist[33][7:5]), 2);
    chk("s6_relock", int'(hist[45][2]), 1);

    // Random traffic
    begin
      int mode = 0, k = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i % 64 == 0) begin
          mode = $urandom_range(0, 3);
          if (mode == 3) mode = 1;
          k = $urandom_range(0, 7);
        end
        RST   = ($urandom_range(0, 199) == 0);
        start = ($urandom_range(0, 15) == 0);
        q     = ($urandom_range(0, 23) == 0) ? 8'($urandom) : q_for(mode, k);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iserdes_bitslip_trainer.md
ISERDES_BITSLIP_TRAINER -- requirements
Module: iserdes_bitslip_trainer

Interface
REQ-001 The block SHALL have parameter TRAIN_PATTERN, default 8'hB4, the expected deserialized word ({Q8..Q1}).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4 (range 1..15), the CLKDIV cycles waited after start or bitslip before comparing.
REQ-003 The block SHALL have parameter MATCH_COUNT, default 8 (range 1..15), the consecutive matches required for lock.
REQ-004 The block SHALL have port CLKDIV, input, 1 bit: clock, the divided clock of the deserializer.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: training request, sampled each cycle.
REQ-007 The block SHALL have port q, input, 8 bits: deserialized word {Q8,Q7,...,Q1}, CLKDIV domain.
REQ-008 The block SHALL have port bitslip, output, 1 bit: single-cycle slip pulse to the deserializer.
REQ-009 The block SHALL have port busy, output, 1 bit: training in progress.
REQ-010 The block SHALL have port locked, output, 1 bit: pattern aligned.
REQ-011 The block SHALL have port fail, output, 1 bit: all 8 alignments tried without lock.
REQ-012 The block SHALL have port slip_count, output, 3 bits: total slips issued since RST, modulo 8.
REQ-013 The block SHALL have port lock_lost, output, 1 bit: sticky, mismatch seen while LOCKED.

Function
REQ-014 All outputs SHALL be registered; states are IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
REQ-015 IDLE, LOCKED or FAIL with start=1 SHALL go to SETTLE, clear the settle counter, match counter, attempt counter and lock_lost; slip_count is kept.
REQ-016 start SHALL be ignored in SETTLE, CHECK and SLIP.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK; q is ignored in SETTLE.
REQ-018 CHECK SHALL compare q to TRAIN_PATTERN every cycle; a match increments the match counter.
REQ-019 In CHECK, the MATCH_COUNT-th consecutive match SHALL go to LOCKED.
REQ-020 A mismatch in CHECK SHALL clear the match counter, go to FAIL if the attempt counter is 7, else go to SLIP.
REQ-021 SLIP SHALL last one cycle with bitslip=1, increment the attempt counter and slip_count (3-bit wrap 7->0), then go to SETTLE.
REQ-022 bitslip SHALL be 1 only in SLIP; consecutive pulses are separated by at least SETTLE_CYCLES+1 low cycles.
REQ-023 busy SHALL be 1 exactly in SETTLE, CHECK and SLIP.
REQ-024 locked SHALL be 1 exactly in LOCKED; fail SHALL be 1 exactly in FAIL.
REQ-025 In LOCKED, q != TRAIN_PATTERN SHALL set lock_lost until the next accepted start or RST; locked stays 1.
REQ-026 With an accepted start at cycle 0 and k slips needed (0..7), locked SHALL rise at cycle 13+6k (defaults).
REQ-027 With no alignment, fail SHALL rise at cycle 48 after 7 bitslip pulses (defaults).

Reset
REQ-028 RST SHALL force IDLE with bitslip=0, busy=0, locked=0, fail=0, lock_lost=0, slip_count=0 and all counters 0 on the next CLKDIV edge.
REQ-029 RST SHALL take priority over start and abort training mid-operation, with no bitslip pulse in the cycle after RST is sampled.

Verification
REQ-030 Scenario: q constant 8'hB4, start pulse at cycle 0 -> busy cycles 1-12, no bitslip, locked=1 at cycle 13, slip_count=0.
REQ-031 Scenario: behavioral deserializer model needing 3 slips -> bitslip pulses at cycles 6, 12 and 18, locked at cycle 31, slip_count=3.
REQ-032 Scenario: q never equals 8'hB4 -> 7 bitslip pulses, fail=1 at cycle 48, busy=0, slip_count=7.
REQ-033 Scenario: 5 matches then 1 mismatch in CHECK -> SLIP issued, match counter restarts, MATCH_COUNT fresh matches are needed to lock.
REQ-034 Scenario: RST asserted at cycle 9 during training -> all outputs are reset values at cycle 10, start at cycle 10 is ignored, start at cycle 11 is accepted.
REQ-035 Scenario: one corrupted word while LOCKED -> lock_lost=1 and locked=1; a new start clears lock_lost and retrains with slip_count preserved.
